ber_counter: RTL and testbench
==============================

Name: ber_counter

Overview:
- Bit-error-rate measurement front end.
- Takes a serial received bit stream, self-synchronises a local PRBS generator to it, then counts received bits and bit errors.
- Its RECV_CNT/ERR_CNT outputs feed the 7-segment BER display handler directly.
- Sits between the receive deserialiser/sampler and the display stage.

Parameters:
- RECV_BW, 58, width of received-bit counter.
- ERR_BW, 64, width of error counter.
- SYNC_LEN, 64, consecutive matching bits required to declare lock (2..255).
- WIN_LEN, 256, loss-of-lock observation window in checked bits (2..65535).
- LOL_THR, 64, errors within one window that force loss of lock (1..WIN_LEN).

Ports:
- CLK, input, 1, clock.
- RST, input, 1, reset: synchronous, active-high. One clock; RST sampled on CLK rising edge.
- DIN, input, 1, received data bit.
- DIN_VALID, input, 1, DIN qualifier; one bit consumed per cycle when high.
- PRBS_SEL, input, 2, pattern: 0=PRBS7 (taps 7,6), 1=PRBS15 (15,14), 2=PRBS23 (23,18), 3=PRBS31 (31,28).
- CLEAR, input, 1, synchronous counter clear.
- LOCKED, output, 1, high while in CHECK.
- SAT, output, 1, counters frozen due to RECV_CNT saturation.
- RECV_CNT, output, RECV_BW, bits checked while locked.
- ERR_CNT, output, ERR_BW, errored bits while locked.

Behaviour:
- Reset values: LOCKED=0, SAT=0, RECV_CNT=0, ERR_CNT=0. Shift register SR[30:0]=0, state=HUNT, bit/window/error sub-counters=0.
- RST mid-operation returns everything to reset values on the next edge, regardless of other inputs.
- SR shifts left; the new bit enters SR[0]. Predicted bit P = SR[a-1]^SR[b-1] for the selected taps (a,b).
- Nothing advances when DIN_VALID=0.
- HUNT:
  - Each valid bit shifts DIN into SR and increments the fill count.
  - When fill count reaches the order (7/15/23/31), go to VERIFY and clear the match count.
- VERIFY:
  - Each valid bit compares DIN with P and shifts DIN into SR.
  - Match: match count +1.
  - Mismatch: go to HUNT with fill count 0; SR keeps its contents.
  - When the match count reaches SYNC_LEN, go to CHECK; LOCKED rises on the same edge.
  - Bits in HUNT/VERIFY are never counted.
- CHECK:
  - Each valid bit: err = DIN^P. SR shifts in P (not DIN), so one line error costs exactly one count.
  - RECV_CNT += 1; ERR_CNT += err.
  - Window counter +1 and window error counter += err.
  - When window errors reach LOL_THR: go to HUNT, LOCKED falls next edge, window counters zero. The bit that hit the threshold is still counted.
  - When the window counter reaches WIN_LEN without hitting the threshold, both window counters restart at 0.
- Latency: counters and LOCKED reflect a valid bit on the edge that samples it, i.e. visible one cycle after DIN_VALID.
- Loss of lock does not clear RECV_CNT/ERR_CNT; they hold until CLEAR or RST.
- CLEAR:
  - Zeroes RECV_CNT, ERR_CNT and SAT; does not affect state, SR, or window counters.
  - CLEAR with a valid CHECK bit in the same cycle: clear wins and that bit is not counted in RECV_CNT/ERR_CNT. It still updates SR and the window counters.
- Saturation:
  - When RECV_CNT equals all-ones, further valid bits change neither counter (ratio stays consistent) and SAT=1.
  - ERR_CNT cannot exceed RECV_CNT, so it never wraps.
- PRBS_SEL is registered internally. Any change forces HUNT (fill count 0, LOCKED=0) on the next edge; SR is cleared; counters hold.
- All-zero SR in VERIFY/CHECK predicts 0 forever. An all-zero input therefore locks, which is accepted behaviour; the source is not expected to send it.

Test Plan:
- Clean PRBS7 stream, DIN_VALID=1 continuously, after reset → LOCKED rises after exactly 7+64=71 valid bits. Then 1000 further bits give RECV_CNT=1000, ERR_CNT=0.
- Locked PRBS15, flip 5 isolated bits spaced 50 apart → ERR_CNT=5 exactly, LOCKED stays 1. Repeat with DIN_VALID toggling 1/0 → identical counts.
- Locked PRBS23, inject 64 errors within 256 bits (LOL_THR=64) → LOCKED falls the cycle after the 64th error, ERR_CNT=64 held. Clean stream resumes → relock after 23+64 bits and counting continues from held values.
- CLEAR asserted with a valid errored bit in CHECK → RECV_CNT=0, ERR_CNT=0 next cycle; the following clean bit gives RECV_CNT=1.
- RECV_BW=8, clean PRBS31 → RECV_CNT stops at 255, SAT=1, ERR_CNT frozen. CLEAR → SAT=0 and counting resumes.
- RST pulsed mid-CHECK, then PRBS_SEL changed while locked → all outputs 0 after RST. The PRBS_SEL change drops LOCKED next edge; relock follows on the new pattern.

Source files
------------

// File: rtl/ber_counter.sv
// PRBS bit-error-rate front end: self-syncs a local PRBS7/15/23/31 predictor to the
// received stream, then counts checked bits and errors while locked.
module ber_counter #(
  parameter int RECV_BW  = 58,
  parameter int ERR_BW   = 64,
  parameter int SYNC_LEN = 64,
  parameter int WIN_LEN  = 256,
  parameter int LOL_THR  = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DIN,
  input  logic              DIN_VALID,
  input  logic [1:0]        PRBS_SEL,
  input  logic              CLEAR,
  output logic              LOCKED,
  output logic              SAT,
  output logic [RECV_BW-1:0] RECV_CNT,
  output logic [ERR_BW-1:0]  ERR_CNT
);

  typedef enum logic [1:0] {HUNT, VERIFY, CHECK} state_t;

  localparam logic [7:0]         SYNC_L   = 8'(SYNC_LEN);
  localparam logic [15:0]        WIN_L    = 16'(WIN_LEN);
  localparam logic [15:0]        LOL_L    = 16'(LOL_THR);
  localparam logic [RECV_BW-1:0] RECV_MAX = '1;

  state_t      state;
  logic [30:0] sr;
  logic [1:0]  sel_q;
  logic [4:0]  fill;
  logic [7:0]  match_cnt;
  logic [15:0] win_cnt, win_err;

  logic        pred, err_bit;
  logic [4:0]  order;
  logic [15:0] win_cnt_nx, win_err_nx;

  always_comb begin
    order = 5'd7;
    pred  = sr[6] ^ sr[5];
    case (sel_q)
      2'd1:    begin order = 5'd15; pred = sr[14] ^ sr[13]; end
      2'd2:    begin order = 5'd23; pred = sr[22] ^ sr[17]; end
      2'd3:    begin order = 5'd31; pred = sr[30] ^ sr[27]; end
      default: ;
    endcase
  end

  assign err_bit    = DIN ^ pred;
  assign win_cnt_nx = win_cnt + 16'd1;
  assign win_err_nx = win_err + 16'(err_bit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= HUNT;
      sr        <= '0;
      sel_q     <= PRBS_SEL;
      fill      <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      LOCKED    <= 1'b0;
      SAT       <= 1'b0;
      RECV_CNT  <= '0;
      ERR_CNT   <= '0;
    end else begin
      if (CLEAR) begin
        RECV_CNT <= '0;
        ERR_CNT  <= '0;
        SAT      <= 1'b0;
      end
      // A pattern change restarts acquisition from an empty predictor; the bit is dropped.
      if (PRBS_SEL != sel_q) begin
        sel_q   <= PRBS_SEL;
        state   <= HUNT;
        sr      <= '0;
        fill    <= '0;
        win_cnt <= '0;
        win_err <= '0;
        LOCKED  <= 1'b0;
      end else if (DIN_VALID) begin
        case (state)
          HUNT: begin
            sr   <= {sr[29:0], DIN};
            fill <= fill + 5'd1;
            if (fill + 5'd1 == order) begin
              state     <= VERIFY;
              match_cnt <= '0;
            end
          end
          VERIFY: begin
            sr <= {sr[29:0], DIN};
            if (!err_bit) begin
              match_cnt <= match_cnt + 8'd1;
              if (match_cnt + 8'd1 == SYNC_L) begin
                state   <= CHECK;
                LOCKED  <= 1'b1;
                win_cnt <= '0;
                win_err <= '0;
              end
            end else begin
              state <= HUNT;
              fill  <= '0;
            end
          end
          CHECK: begin
            // Feeding back the prediction keeps a line error from corrupting later predictions.
            sr <= {sr[29:0], pred};
            if (!CLEAR && RECV_CNT != RECV_MAX) begin
              RECV_CNT <= RECV_CNT + RECV_BW'(1);
              ERR_CNT  <= ERR_CNT + ERR_BW'(err_bit);
              SAT      <= (RECV_CNT + RECV_BW'(1)) == RECV_MAX;
            end
            if (win_err_nx == LOL_L) begin
              state   <= HUNT;
              fill    <= '0;
              LOCKED  <= 1'b0;
              win_cnt <= '0;
              win_err <= '0;
            end else if (win_cnt_nx == WIN_L) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt_nx;
              win_err <= win_err_nx;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ber_counter.sv
// Bench for ber_counter: directed phases plus random traffic, all checked each cycle
// against a queue-based behavioural model (two instances: wide and 8-bit counters).
module tb_ber_counter;

  logic       CLK = 1'b0, RST = 1'b1, DIN = 1'b0, DIN_VALID = 1'b0, CLEAR = 1'b0;
  logic [1:0] PRBS_SEL = 2'd0;

  logic        locked_a, sat_a, locked_b, sat_b;
  logic [57:0] recv_a;
  logic [63:0] errc_a;
  logic [7:0]  recv_b, errc_b;

  ber_counter dut_a (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .PRBS_SEL(PRBS_SEL),
    .CLEAR(CLEAR), .LOCKED(locked_a), .SAT(sat_a), .RECV_CNT(recv_a), .ERR_CNT(errc_a)
  );

  ber_counter #(.RECV_BW(8), .ERR_BW(8)) dut_b (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .PRBS_SEL(PRBS_SEL),
    .CLEAR(CLEAR), .LOCKED(locked_b), .SAT(sat_b), .RECV_CNT(recv_b), .ERR_CNT(errc_b)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Pattern order and second tap, indexed by PRBS_SEL.
  int ord_t[4] = '{7, 15, 23, 31};
  int tb_t[4]  = '{6, 14, 18, 28};

  // Behavioural model: the predictor is a history queue of the last 31 shifted bits.
  int          m_mode, m_fill, m_match, m_win, m_werr;
  bit          m_locked;
  bit          hq[$];
  logic [1:0]  m_sel;
  longint unsigned m_recv[2], m_err[2];
  bit          m_sat[2];
  longint unsigned m_max[2] = '{(64'd1 << 58) - 64'd1, 64'd255};

  function automatic bit tap(int k);
    if (hq.size() >= k) return hq[hq.size() - k];
    return 1'b0;
  endfunction

  function automatic void push(bit b);
    hq.push_back(b);
    if (hq.size() > 31) void'(hq.pop_front());
  endfunction

  function automatic void model_step();
    bit p, e;
    if (RST) begin
      m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_locked = 0;
      hq.delete(); m_sel = PRBS_SEL;
      for (int i = 0; i < 2; i++) begin m_recv[i] = 0; m_err[i] = 0; m_sat[i] = 0; end
      return;
    end
    if (PRBS_SEL != m_sel) begin
      m_sel = PRBS_SEL; m_mode = 0; m_fill = 0; hq.delete();
      m_win = 0; m_werr = 0; m_locked = 0;
    end else if (DIN_VALID) begin
      p = tap(ord_t[m_sel]) ^ tap(tb_t[m_sel]);
      if (m_mode == 0) begin
        push(DIN); m_fill++;
        if (m_fill == ord_t[m_sel]) begin m_mode = 1; m_match = 0; end
      end else if (m_mode == 1) begin
        push(DIN);
        if (DIN == p) begin
          m_match++;
          if (m_match == 64) begin m_mode = 2; m_locked = 1; m_win = 0; m_werr = 0; end
        end else begin
          m_mode = 0; m_fill = 0;
        end
      end else begin
        e = DIN ^ p;
        push(p);
        if (!CLEAR)
          for (int i = 0; i < 2; i++)
            if (m_recv[i] != m_max[i]) begin
              m_recv[i]++; m_err[i] += 64'(e); m_sat[i] = (m_recv[i] == m_max[i]);
            end
        m_win++; m_werr += int'(e);
        if (m_werr == 64) begin
          m_mode = 0; m_fill = 0; m_locked = 0; m_win = 0; m_werr = 0;
        end else if (m_win == 256) begin
          m_win = 0; m_werr = 0;
        end
      end
    end
    if (CLEAR)
      for (int i = 0; i < 2; i++) begin m_recv[i] = 0; m_err[i] = 0; m_sat[i] = 0; end
  endfunction

  always @(negedge CLK) if (chk_en) begin
    chk("locked_a", 64'(locked_a), 64'(m_locked));
    chk("locked_b", 64'(locked_b), 64'(m_locked));
    chk("sat_a",    64'(sat_a),    64'(m_sat[0]));
    chk("sat_b",    64'(sat_b),    64'(m_sat[1]));
    chk("recv_a",   64'(recv_a),   m_recv[0]);
    chk("err_a",    errc_a,        m_err[0]);
    chk("recv_b",   64'(recv_b),   m_recv[1]);
    chk("err_b",    64'(errc_b),   m_err[1]);
  end

  // Stimulus PRBS source.
  logic [30:0] gh;
  logic [1:0]  gsel;

  function automatic bit gen();
    bit b;
    b  = gh[ord_t[gsel] - 1] ^ gh[tb_t[gsel] - 1];
    gh = {gh[29:0], b};
    return b;
  endfunction

  task automatic reseed(logic [1:0] s);
    gsel = s;
    gh   = 31'($urandom) | 31'd1;
  endtask

  task automatic cyc(bit d, bit v, bit c);
    DIN = d; DIN_VALID = v; CLEAR = c;
    @(posedge CLK);
    #1;
    model_step();
  endtask

  // gap: 0 = back-to-back, 1 = valid toggles 1/0, 2 = random idle cycles
  task automatic send(int n, int err_rate, int gap);
    bit b;
    for (int i = 0; i < n; i++) begin
      while (gap == 2 && $urandom_range(0, 3) == 0) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      b = gen();
      if (int'($urandom_range(0, 999)) < err_rate) b = ~b;
      cyc(b, 1'b1, 1'b0);
      if (gap == 1) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic send_err(int gap);
    cyc(~gen(), 1'b1, 1'b0);
    if (gap == 1) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic newsel(logic [1:0] s);
    PRBS_SEL = s;
    reseed(s);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  int rates[5] = '{0, 0, 3, 50, 400};

  initial begin
    RST = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    chk("rst_locked", 64'(locked_a), 64'd0);
    chk("rst_recv",   64'(recv_a),   64'd0);
    RST = 1'b0;

    // Clean PRBS7 lock after exactly 7+64 bits, then 1000 clean counted bits.
    reseed(2'd0);
    send(70, 0, 0);
    chk("p7_no_lock_70", 64'(locked_a), 64'd0);
    send(1, 0, 0);
    chk("p7_lock_71", 64'(locked_a), 64'd1);
    send(1000, 0, 0);
    chk("p7_recv_1000", 64'(recv_a), 64'd1000);
    chk("p7_err_0",     errc_a,      64'd0);
    chk("b_sat_255",    64'(recv_b), 64'd255);
    chk("b_sat_flag",   64'(sat_b),  64'd1);

    // CLEAR with an errored valid bit: clear wins.
    cyc(~gen(), 1'b1, 1'b1);
    chk("clr_recv", 64'(recv_a), 64'd0);
    chk("clr_err",  errc_a,      64'd0);
    chk("clr_sat_b", 64'(sat_b), 64'd0);
    send(1, 0, 0);
    chk("clr_next_recv", 64'(recv_a), 64'd1);

    // PRBS15, 5 isolated errors, contiguous and then with toggled valid.
    newsel(2'd1);
    chk("p15_sel_unlock", 64'(locked_a), 64'd0);
    send(79, 0, 2);
    chk("p15_lock", 64'(locked_a), 64'd1);
    for (int g = 0; g < 2; g++) begin
      cyc(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin send(49, 0, g); send_err(g); end
      chk("p15_err5",   errc_a,           64'd5);
      chk("p15_recv",   64'(recv_a),      64'd250);
      chk("p15_locked", 64'(locked_a),    64'd1);
    end

    // PRBS23, 64 errors inside one window force loss of lock; relock keeps counts.
    newsel(2'd2);
    send(87, 0, 0);
    chk("p23_lock", 64'(locked_a), 64'd1);
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 63; k++) begin send_err(0); send(1, 0, 0); end
    chk("p23_63_locked", 64'(locked_a), 64'd1);
    send_err(0);
    chk("p23_lol",      64'(locked_a), 64'd0);
    chk("p23_err64",    errc_a,        64'd64);
    chk("p23_recv127",  64'(recv_a),   64'd127);
    send(86, 0, 0);
    chk("p23_relock_early", 64'(locked_a), 64'd0);
    send(1, 0, 0);
    chk("p23_relock", 64'(locked_a), 64'd1);
    chk("p23_held",   errc_a,        64'd64);
    send(10, 0, 0);
    chk("p23_resume", 64'(recv_a), 64'd137);

    // PRBS31 saturation of the 8-bit instance, then CLEAR resumes counting.
    newsel(2'd3);
    send(95, 0, 2);
    chk("p31_lock", 64'(locked_a), 64'd1);
    cyc(1'b0, 1'b0, 1'b1);
    send(300, 0, 0);
    chk("p31_sat_recv", 64'(recv_b), 64'd255);
    chk("p31_sat",      64'(sat_b),  64'd1);
    chk("p31_recv_a",   64'(recv_a), 64'd300);
    cyc(1'b0, 1'b0, 1'b1);
    send(5, 0, 0);
    chk("p31_resume", 64'(recv_b), 64'd5);
    chk("p31_unsat",  64'(sat_b),  64'd0);

    // RST mid-CHECK, relock, then a pattern change while locked.
    RST = 1'b1;
    cyc(gen(), 1'b1, 1'b0);
    RST = 1'b0;
    chk("rst_mid_locked", 64'(locked_a), 64'd0);
    chk("rst_mid_recv",   64'(recv_a),   64'd0);
    chk("rst_mid_err",    errc_a,        64'd0);
    reseed(2'd3);
    send(95, 0, 0);
    chk("rst_relock", 64'(locked_a), 64'd1);
    newsel(2'd0);
    chk("sel_drop", 64'(locked_a), 64'd0);
    send(71, 0, 0);
    chk("sel_relock", 64'(locked_a), 64'd1);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0: newsel(2'($urandom_range(0, 3)));
        1: cyc(1'b0, 1'b0, 1'b1);
        2: begin RST = 1'b1; cyc(1'b0, 1'b0, 1'b0); RST = 1'b0; end
        default: ;
      endcase
      send(int'($urandom_range(20, 300)), rates[$urandom_range(0, 4)], int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
